// File: rtl/universal_reg_pkg.sv
// ---------------------------------------------------------------------------
// ureg_pkg: shared definitions for universal_reg.
//   mode_e      - 3-bit operation select values driven on universal_reg.Mode
//   is_shift()  - true for the four modes that advance the frame counter
// ---------------------------------------------------------------------------
package ureg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_LOAD   = 3'b001,
    MODE_SHL    = 3'b010,
    MODE_SHR    = 3'b011,
    MODE_ROL    = 3'b100,
    MODE_ROR    = 3'b101,
    MODE_CLEAR  = 3'b110,
    MODE_HOLD_2 = 3'b111   // second HOLD encoding
  } mode_e;

  function automatic logic is_shift(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) ||
           (mode == MODE_ROL) || (mode == MODE_ROR);
  endfunction

endpackage

// File: rtl/dff_cell.sv
// ---------------------------------------------------------------------------
// dff_cell: one-bit D flip-flop with synchronous active-high reset.
//   clk_i  - clock, rising edge
//   rst_i  - synchronous reset, loads RST_VAL
//   d_i    - next value
//   q_o    - registered value
// ---------------------------------------------------------------------------
module dff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) q_o <= RST_VAL;
    else       q_o <= d_i;
  end

endmodule

// File: rtl/universal_reg.sv
// ---------------------------------------------------------------------------
// universal_reg: WIDTH-bit universal shift register with frame counter.
//   Clk        - clock, all state on rising edge
//   Reset      - synchronous active-high reset (Q=RESET_VAL, counter 0)
//   Mode       - operation select (see ureg_pkg::mode_e)
//   D          - parallel load data
//   Sin_L      - serial bit entering Q[0] on shift left
//   Sin_R      - serial bit entering Q[WIDTH-1] on shift right
//   Q          - register contents
//   Sout_L     - Q[WIDTH-1], combinational
//   Sout_R     - Q[0], combinational
//   Frame      - one-cycle pulse after the WIDTH-th shift/rotate of a frame
//   Shift_cnt  - shift/rotate operations so far in the current frame
// There is no handshake: a new Mode is accepted every cycle and its result
// is visible on Q the cycle after the sampling edge.
// ---------------------------------------------------------------------------
module universal_reg
  import ureg_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [2:0]               Mode,
  input  logic [WIDTH-1:0]         D,
  input  logic                     Sin_L,
  input  logic                     Sin_R,
  output logic [WIDTH-1:0]         Q,
  output logic                     Sout_L,
  output logic                     Sout_R,
  output logic                     Frame,
  output logic [$clog2(WIDTH)-1:0] Shift_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_q, frame_d;

  // Next-state data mux; HOLD (both encodings) keeps Q.
  always_comb begin
    q_d = Q;
    case (Mode)
      MODE_LOAD:  q_d = D;
      MODE_SHL:   q_d = {Q[WIDTH-2:0], Sin_L};
      MODE_SHR:   q_d = {Sin_R, Q[WIDTH-1:1]};
      MODE_ROL:   q_d = {Q[WIDTH-2:0], Q[WIDTH-1]};
      MODE_ROR:   q_d = {Q[0], Q[WIDTH-1:1]};
      MODE_CLEAR: q_d = RESET_VAL;
      default:    q_d = Q;
    endcase
  end

  // Frame counter counts shift cycles only; direction changes do not
  // restart it, HOLD pauses it, LOAD/CLEAR discard the partial frame.
  always_comb begin
    cnt_d   = cnt_q;
    frame_d = 1'b0;
    if (is_shift(Mode)) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        frame_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (Mode == MODE_LOAD || Mode == MODE_CLEAR) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  // Storage: one flop per bit, each with its own reset value.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_cell #(.RST_VAL(RESET_VAL[i])) u_cell (
      .clk_i (Clk),
      .rst_i (Reset),
      .d_i   (q_d[i]),
      .q_o   (Q[i])
    );
  end

  assign Sout_L    = Q[WIDTH-1];
  assign Sout_R    = Q[0];
  assign Frame     = frame_q;
  assign Shift_cnt = cnt_q;

endmodule

// File: tb/tb_universal_reg.sv
module tb_universal_reg;
  import ureg_pkg::*;

  localparam int W = 31;  // {chk_chain, up_q[8], dn_q[8], q[8], frame, cnt[3], sout_l, sout_r}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, c_rst;
  logic [2:0] mode, c_mode;
  logic [7:0] d, up_d, dn_d;
  logic       sl, sr;

  logic [7:0] q, up_q, dn_q;
  logic       sout_l, sout_r, frame;
  logic [2:0] cnt;
  logic       up_sl_o, up_sr_o, up_fr, dn_sl_o, dn_sr_o, dn_fr;
  logic [2:0] up_cnt, dn_cnt;

  universal_reg #(.WIDTH(8), .RESET_VAL(8'h3C)) dut (
    .Clk(clk), .Reset(rst), .Mode(mode), .D(d), .Sin_L(sl), .Sin_R(sr),
    .Q(q), .Sout_L(sout_l), .Sout_R(sout_r), .Frame(frame), .Shift_cnt(cnt)
  );

  // Chained pair: upstream Sout_L feeds downstream Sin_L.
  universal_reg #(.WIDTH(8), .RESET_VAL(8'h00)) u_up (
    .Clk(clk), .Reset(c_rst), .Mode(c_mode), .D(up_d), .Sin_L(1'b0), .Sin_R(1'b0),
    .Q(up_q), .Sout_L(up_sl_o), .Sout_R(up_sr_o), .Frame(up_fr), .Shift_cnt(up_cnt)
  );

  universal_reg #(.WIDTH(8), .RESET_VAL(8'h00)) u_dn (
    .Clk(clk), .Reset(c_rst), .Mode(c_mode), .D(dn_d), .Sin_L(up_sl_o), .Sin_R(1'b0),
    .Q(dn_q), .Sout_L(dn_sl_o), .Sout_R(dn_sr_o), .Frame(dn_fr), .Shift_cnt(dn_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  task automatic check(input string name, input int stp, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, stp, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of stimulus on both the main DUT and the chain, then
  // pushes the hand-computed state expected after the sampling edge.
  task automatic drive(input logic r, input logic [2:0] m, input logic [7:0] dv,
                       input logic s_l, input logic s_r,
                       input logic [7:0] eq, input logic ef, input logic [2:0] ec,
                       input logic cr, input logic [2:0] cm,
                       input logic [7:0] cud, input logic [7:0] cdd,
                       input logic chk_c, input logic [7:0] e_up, input logic [7:0] e_dn);
    @(negedge clk);
    rst = r; mode = m; d = dv; sl = s_l; sr = s_r;
    c_rst = cr; c_mode = cm; up_d = cud; dn_d = cdd;
    @(posedge clk);
    #1;
    exp_q.push_back({chk_c, e_up, e_dn, eq, ef, ec, eq[7], eq[0]});
  endtask

  // Main-DUT step with the chain parked in HOLD.
  task automatic op(input logic r, input logic [2:0] m, input logic [7:0] dv,
                    input logic s_l, input logic s_r,
                    input logic [7:0] eq, input logic ef, input logic [2:0] ec);
    drive(r, m, dv, s_l, s_r, eq, ef, ec, 1'b0, MODE_HOLD, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step_no++;
        check("q",      step_no, 32'(q),      32'(e[13:6]));
        check("frame",  step_no, 32'(frame),  32'(e[5]));
        check("cnt",    step_no, 32'(cnt),    32'(e[4:2]));
        check("sout_l", step_no, 32'(sout_l), 32'(e[1]));
        check("sout_r", step_no, 32'(sout_r), 32'(e[0]));
        if (e[30]) begin
          check("chain_up_q", step_no, 32'(up_q), 32'(e[29:22]));
          check("chain_dn_q", step_no, 32'(dn_q), 32'(e[21:14]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rol_seq [8]  = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
    logic [7:0] ror_seq [8]  = '{8'h7D, 8'hBE, 8'h5F, 8'hAF, 8'hD7, 8'hEB, 8'hF5, 8'hFA};
    logic [7:0] up_seq  [8]  = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    logic [7:0] dn_seq  [8]  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    int guard;

    rst = 1'b1; mode = MODE_HOLD; d = '0; sl = 1'b0; sr = 1'b0;
    c_rst = 1'b1; c_mode = MODE_HOLD; up_d = '0; dn_d = '0;

    // Reset beats LOAD; both instances reset together.
    drive(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0, 8'h3C, 1'b0, 3'd0,
          1'b1, MODE_HOLD, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00);
    op(1'b0, MODE_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 3'd0);
    op(1'b0, MODE_SHL,  8'h00, 1'b1, 1'b0, 8'h4B, 1'b0, 3'd1);
    op(1'b0, MODE_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 3'd0);
    op(1'b0, MODE_SHR,  8'h00, 1'b0, 1'b0, 8'h52, 1'b0, 3'd1);

    // Rotate a full frame; serial inputs set opposite to prove they are ignored.
    op(1'b0, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++)
      op(1'b0, MODE_ROL, 8'h00, ~rol_seq[i][0], 1'b1, rol_seq[i], (i == 7), 3'((i + 1) % 8));
    op(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 3'd0);

    // SHR x5, HOLD x3 (both encodings), SHR x3.
    op(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h40, 1'b0, 3'd1);
    op(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h20, 1'b0, 3'd2);
    op(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 3'd3);
    op(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 3'd4);
    op(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 3'd5);
    op(1'b0, MODE_HOLD,   8'hFF, 1'b1, 1'b1, 8'h04, 1'b0, 3'd5);
    op(1'b0, MODE_HOLD_2, 8'hFF, 1'b1, 1'b1, 8'h04, 1'b0, 3'd5);
    op(1'b0, MODE_HOLD,   8'hFF, 1'b1, 1'b1, 8'h04, 1'b0, 3'd5);
    op(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 3'd6);
    op(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 3'd7);
    op(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0);

    // Mixed directions across a frame, then a back-to-back ROR frame.
    op(1'b0, MODE_LOAD, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 3'd0);
    op(1'b0, MODE_SHL, 8'h00, 1'b1, 1'b0, 8'hB5, 1'b0, 3'd1);
    op(1'b0, MODE_SHL, 8'h00, 1'b1, 1'b0, 8'h6B, 1'b0, 3'd2);
    op(1'b0, MODE_SHL, 8'h00, 1'b1, 1'b0, 8'hD7, 1'b0, 3'd3);
    op(1'b0, MODE_SHL, 8'h00, 1'b1, 1'b0, 8'hAF, 1'b0, 3'd4);
    op(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b1, 8'hD7, 1'b0, 3'd5);
    op(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b1, 8'hEB, 1'b0, 3'd6);
    op(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b1, 8'hF5, 1'b0, 3'd7);
    op(1'b0, MODE_SHR, 8'h00, 1'b0, 1'b1, 8'hFA, 1'b1, 3'd0);
    for (int i = 0; i < 8; i++)
      op(1'b0, MODE_ROR, 8'h00, 1'b1, ~ror_seq[i][7], ror_seq[i], (i == 7), 3'((i + 1) % 8));

    // CLEAR discards a partial frame and loads RESET_VAL.
    op(1'b0, MODE_SHL,   8'h00, 1'b0, 1'b0, 8'hF4, 1'b0, 3'd1);
    op(1'b0, MODE_SHL,   8'h00, 1'b0, 1'b0, 8'hE8, 1'b0, 3'd2);
    op(1'b0, MODE_CLEAR, 8'hFF, 1'b1, 1'b1, 8'h3C, 1'b0, 3'd0);

    // SHL x4, Reset mid-frame, SHL x4: no Frame pulse.
    op(1'b0, MODE_SHL, 8'h00, 1'b0, 1'b0, 8'h78, 1'b0, 3'd1);
    op(1'b0, MODE_SHL, 8'h00, 1'b0, 1'b0, 8'hF0, 1'b0, 3'd2);
    op(1'b0, MODE_SHL, 8'h00, 1'b0, 1'b0, 8'hE0, 1'b0, 3'd3);
    op(1'b0, MODE_SHL, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b0, 3'd4);
    op(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 3'd0);
    op(1'b0, MODE_SHL, 8'h00, 1'b1, 1'b0, 8'h79, 1'b0, 3'd1);
    op(1'b0, MODE_SHL, 8'h00, 1'b1, 1'b0, 8'hF3, 1'b0, 3'd2);
    op(1'b0, MODE_SHL, 8'h00, 1'b1, 1'b0, 8'hE7, 1'b0, 3'd3);
    op(1'b0, MODE_SHL, 8'h00, 1'b1, 1'b0, 8'hCF, 1'b0, 3'd4);

    // Chain: LOAD 0xFF/0x00 then SHL x8 while the main DUT holds.
    drive(1'b0, MODE_HOLD_2, 8'h00, 1'b0, 1'b0, 8'hCF, 1'b0, 3'd4,
          1'b0, MODE_LOAD, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00);
    for (int i = 0; i < 8; i++)
      drive(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 8'hCF, 1'b0, 3'd4,
            1'b0, MODE_SHL, 8'h00, 8'h00, 1'b1, up_seq[i], dn_seq[i]);

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("drain_queue_empty", step_no, 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
